// File: rtl/rv_iommu_pkg.sv
// Shared rv_iommu types: HPM event indices and the event-queue entry format.
package rv_iommu_pkg;

  localparam int N_HPM_EVT = 6;

  typedef enum logic [2:0] {
    UT_REQ     = 3'd0,
    IOTLB_MISS = 3'd1,
    DDT_WALK   = 3'd2,
    PDT_WALK   = 3'd3,
    S1_PTW     = 3'd4,
    S2_PTW     = 3'd5
  } hpm_evt_e;

  typedef struct packed {
    logic [N_HPM_EVT-1:0] mask;
    logic [23:0]          did;
    logic [19:0]          pid;
    logic [19:0]          pscid;
    logic [15:0]          gscid;
    logic                 pid_v;
  } hpm_evq_entry_t;

  typedef enum logic {
    EVQ_IDLE = 1'b0,
    EVQ_EMIT = 1'b1
  } hpm_evq_st_e;

  function automatic hpm_evt_e lowest_evt(input logic [N_HPM_EVT-1:0] m);
    lowest_evt = UT_REQ;
    for (int i = N_HPM_EVT - 1; i >= 0; i--)
      if (m[i]) lowest_evt = hpm_evt_e'(3'(i));
  endfunction

endpackage

// File: rtl/rv_iommu_hpm_evq_fifo.sv
// Synchronous FIFO of HPM event entries; extra pointer MSB separates full from empty.
module rv_iommu_hpm_evq_fifo
  import rv_iommu_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           flush_i,
  input  logic           push_i,
  input  logic           pop_i,
  input  hpm_evq_entry_t wdata_i,
  output hpm_evq_entry_t head_o,
  output logic           full_o,
  output logic           empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  hpm_evq_entry_t mem_q [DEPTH];
  hpm_evq_entry_t mem_d [DEPTH];

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign head_o  = mem_q[rptr_q[AW-1:0]];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    mem_d  = mem_q;
    if (flush_i) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      // A pop in the same cycle frees the head slot, so a full queue still accepts.
      if (push_i && (!full_o || pop_i)) begin
        mem_d[wptr_q[AW-1:0]] = wdata_i;
        wptr_d = wptr_q + 1'b1;
      end
      if (pop_i && !empty_o) rptr_d = rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      mem_q  <= mem_d;
    end
  end

endmodule

// File: rtl/rv_iommu_hpm_evq.sv
// HPM event queue: buffers event strobes + IDs and replays them as single-cycle one-hot pulses.
// Optional saturating drop counter under macro RV_IOMMU_HPM_EVQ_DROP_CNT_EN.
module rv_iommu_hpm_evq
  import rv_iommu_pkg::*;
#(
  parameter int EVQ_DEPTH = 8
`ifdef RV_IOMMU_HPM_EVQ_DROP_CNT_EN
  , parameter int DROP_CNT_W = 16
`endif
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [5:0]  evt_i,
  input  logic [23:0] did_i,
  input  logic [19:0] pid_i,
  input  logic [19:0] pscid_i,
  input  logic [15:0] gscid_i,
  input  logic        pid_v_i,
  input  logic        flush_i,
  output logic [5:0]  evt_o,
  output logic [23:0] did_o,
  output logic [19:0] pid_o,
  output logic [19:0] pscid_o,
  output logic [15:0] gscid_o,
  output logic        pid_v_o,
  output logic        ovf_o
`ifdef RV_IOMMU_HPM_EVQ_DROP_CNT_EN
  , output logic [DROP_CNT_W-1:0] drop_cnt_o
`endif
);

  hpm_evq_entry_t in_ent, head, cur, work_q, work_d, out_q, out_d;
  hpm_evq_st_e    state_q, state_d;
  hpm_evt_e       b, last_q, last_d;
  logic           last_v_q, last_v_d;
  logic           full, empty, push, pop, drop, ovf_q, ovf_d;

  assign in_ent = '{mask: evt_i, did: did_i, pid: pid_i, pscid: pscid_i,
                    gscid: gscid_i, pid_v: pid_v_i};

  rv_iommu_hpm_evq_fifo #(.DEPTH(EVQ_DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (flush_i),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (in_ent),
    .head_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

  always_comb begin
    cur      = work_q;
    pop      = 1'b0;
    out_d    = out_q;
    out_d.mask = '0;
    last_d   = last_q;
    last_v_d = 1'b0;
    // Idle: the head is popped and its first bit emitted in the same cycle (load path).
    if (state_q == EVQ_IDLE) begin
      cur = head;
      if (empty) cur.mask = '0;
      pop = !empty && !flush_i;
    end
    b      = lowest_evt(cur.mask);
    work_d = cur;
    // Same type as last cycle's pulse waits one cycle so the HPM edge detector sees two events.
    if ((cur.mask != '0) && !(last_v_q && (b == last_q))) begin
      work_d.mask[b] = 1'b0;
      out_d          = cur;
      out_d.mask     = '0;
      out_d.mask[b]  = 1'b1;
      last_d         = b;
      last_v_d       = 1'b1;
    end
    push  = (|evt_i) && !flush_i;
    drop  = push && full && !pop;
    ovf_d = ovf_q | drop;
    if (flush_i) begin
      work_d.mask = '0;
      out_d.mask  = '0;
      last_v_d    = 1'b0;
      ovf_d       = 1'b0;
    end
    state_d = (work_d.mask != '0) ? EVQ_EMIT : EVQ_IDLE;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= EVQ_IDLE;
      work_q   <= '0;
      out_q    <= '0;
      last_q   <= UT_REQ;
      last_v_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      out_q    <= out_d;
      last_q   <= last_d;
      last_v_q <= last_v_d;
      ovf_q    <= ovf_d;
    end
  end

  assign evt_o   = out_q.mask;
  assign did_o   = out_q.did;
  assign pid_o   = out_q.pid;
  assign pscid_o = out_q.pscid;
  assign gscid_o = out_q.gscid;
  assign pid_v_o = out_q.pid_v;
  assign ovf_o   = ovf_q;

`ifdef RV_IOMMU_HPM_EVQ_DROP_CNT_EN
  logic [DROP_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (drop && !(&cnt_q)) cnt_d = cnt_q + 1'b1;
    if (flush_i) cnt_d = '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign drop_cnt_o = cnt_q;
`endif

endmodule

// File: tb/tb_rv_iommu_hpm_evq.sv
// Directed bench for rv_iommu_hpm_evq: latency, splitting, spacing, overflow, flush, async reset.
module tb_rv_iommu_hpm_evq;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  evt_i = '0;
  logic [23:0] did_i = '0;
  logic [19:0] pid_i = '0;
  logic [19:0] pscid_i = '0;
  logic [15:0] gscid_i = '0;
  logic        pid_v_i = 1'b0;
  logic        flush_i = 1'b0;
  logic [5:0]  evt_o;
  logic [23:0] did_o;
  logic [19:0] pid_o, pscid_o;
  logic [15:0] gscid_o;
  logic        pid_v_o, ovf_o;

  int pass_cnt = 0;
  int total    = 0;

  always #5 clk = ~clk;

`ifdef RV_IOMMU_HPM_EVQ_DROP_CNT_EN
  logic [15:0] drop_cnt_o;
  logic [1:0]  drop2_o;
  logic [5:0]  evt2_o;
  logic [23:0] did2_o;
  logic [19:0] pid2_o, pscid2_o;
  logic [15:0] gscid2_o;
  logic        pid_v2_o, ovf2_o;

  rv_iommu_hpm_evq #(.EVQ_DEPTH(8), .DROP_CNT_W(2)) dut2 (
    .clk_i(clk), .rst_i(rst), .evt_i(evt_i), .did_i(did_i), .pid_i(pid_i),
    .pscid_i(pscid_i), .gscid_i(gscid_i), .pid_v_i(pid_v_i), .flush_i(flush_i),
    .evt_o(evt2_o), .did_o(did2_o), .pid_o(pid2_o), .pscid_o(pscid2_o),
    .gscid_o(gscid2_o), .pid_v_o(pid_v2_o), .ovf_o(ovf2_o), .drop_cnt_o(drop2_o)
  );
`endif

  rv_iommu_hpm_evq #(.EVQ_DEPTH(8)) dut (
    .clk_i(clk), .rst_i(rst), .evt_i(evt_i), .did_i(did_i), .pid_i(pid_i),
    .pscid_i(pscid_i), .gscid_i(gscid_i), .pid_v_i(pid_v_i), .flush_i(flush_i),
    .evt_o(evt_o), .did_o(did_o), .pid_o(pid_o), .pscid_o(pscid_o),
    .gscid_o(gscid_o), .pid_v_o(pid_v_o), .ovf_o(ovf_o)
`ifdef RV_IOMMU_HPM_EVQ_DROP_CNT_EN
    , .drop_cnt_o(drop_cnt_o)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Advance one clock; outputs are sampled 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int          acc [11] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 13};
    logic [5:0]  exp_evt;
    int          p;

    rst = 1'b1;
    #22;
    chk("rst_evt", 32'(evt_o), 0);
    chk("rst_did", 32'(did_o), 0);
    chk("rst_pidv", 32'(pid_v_o), 0);
    chk("rst_ovf", 32'(ovf_o), 0);
`ifdef RV_IOMMU_HPM_EVQ_DROP_CNT_EN
    chk("rst_drop", 32'(drop_cnt_o), 0);
`endif
    @(negedge clk);
    rst = 1'b0;
    step(); step();

    // Single tr_request: pulse two cycles later, IDs held afterwards.
    evt_i = 6'b000001; did_i = 24'h123; pid_i = 20'h11; pid_v_i = 1'b1;
    pscid_i = 20'h22; gscid_i = 16'h33;
    step();
    evt_i = '0; did_i = 24'hFFF; pid_v_i = 1'b0;
    chk("single_t1", 32'(evt_o), 0);
    step();
    chk("single_evt", 32'(evt_o), 32'h01);
    chk("single_did", 32'(did_o), 32'h123);
    chk("single_pid", 32'(pid_o), 32'h11);
    chk("single_pidv", 32'(pid_v_o), 1);
    chk("single_pscid", 32'(pscid_o), 32'h22);
    chk("single_gscid", 32'(gscid_o), 32'h33);
    step();
    chk("single_t3", 32'(evt_o), 0);
    chk("single_hold", 32'(did_o), 32'h123);

    // Multi-bit entry splits into consecutive pulses, lowest bit first.
    evt_i = 6'b010011; did_i = 24'hABCDE;
    step();
    evt_i = '0; did_i = '0;
    chk("multi_t1", 32'(evt_o), 0);
    step();
    chk("multi_p0", 32'(evt_o), 32'h01); chk("multi_d0", 32'(did_o), 32'hABCDE);
    step();
    chk("multi_p1", 32'(evt_o), 32'h02); chk("multi_d1", 32'(did_o), 32'hABCDE);
    step();
    chk("multi_p2", 32'(evt_o), 32'h10); chk("multi_d2", 32'(did_o), 32'hABCDE);
    step();
    chk("multi_end", 32'(evt_o), 0);

    // Same type twice in a row: one idle cycle between pulses.
    evt_i = 6'b000010; did_i = 24'h1;
    step();
    evt_i = 6'b000010; did_i = 24'h2;
    step();
    evt_i = '0;
    chk("same_p0", 32'(evt_o), 32'h02); chk("same_d0", 32'(did_o), 1);
    step();
    chk("same_gap", 32'(evt_o), 0); chk("same_gap_hold", 32'(did_o), 1);
    step();
    chk("same_p1", 32'(evt_o), 32'h02); chk("same_d1", 32'(did_o), 2);
    step();
    chk("same_end", 32'(evt_o), 0);

    // Distinct types from separate entries go back-to-back.
    evt_i = 6'b000001; did_i = 24'h5;
    step();
    evt_i = 6'b000100; did_i = 24'h6;
    step();
    evt_i = '0;
    chk("b2b_p0", 32'(evt_o), 32'h01);
    step();
    chk("b2b_p1", 32'(evt_o), 32'h04); chk("b2b_d1", 32'(did_o), 6);
    step(); step();

    // Overflow: 16 six-bit entries against a depth-8 queue; entries 10,11,12,14,15 drop.
    for (int k = 0; k < 70; k++) begin
      if (k < 16) begin evt_i = 6'h3F; did_i = 24'(k); end
      else        begin evt_i = '0;    did_i = '0;     end
      step();
      if (k >= 1 && k <= 66) begin
        p = k - 1;
        exp_evt = 6'(1 << (p % 6));
        chk("ovf_seq_evt", 32'(evt_o), 32'(exp_evt));
        chk("ovf_seq_did", 32'(did_o), 32'(acc[p / 6]));
      end
      if (k == 67) chk("ovf_seq_end", 32'(evt_o), 0);
      if (k == 9)  chk("ovf_before", 32'(ovf_o), 0);
      if (k == 10) chk("ovf_first", 32'(ovf_o), 1);
    end
    chk("ovf_sticky", 32'(ovf_o), 1);
`ifdef RV_IOMMU_HPM_EVQ_DROP_CNT_EN
    chk("drop_cnt", 32'(drop_cnt_o), 5);
    chk("drop_sat", 32'(drop2_o), 3);
`endif

    // Flush during emission with four entries queued.
    for (int f = 0; f < 5; f++) begin
      evt_i = 6'h3F; did_i = 24'h100 + 24'(f);
      step();
    end
    chk("flush_pre", 32'(evt_o), 32'h08);
    flush_i = 1'b1; evt_i = 6'h3F; did_i = 24'h999;
    step();
    flush_i = 1'b0; evt_i = '0;
    chk("flush_evt", 32'(evt_o), 0);
    chk("flush_ovf", 32'(ovf_o), 0);
    chk("flush_hold", 32'(did_o), 32'h100);
`ifdef RV_IOMMU_HPM_EVQ_DROP_CNT_EN
    chk("flush_drop", 32'(drop_cnt_o), 0);
`endif
    for (int i = 0; i < 10; i++) begin
      step();
      chk("flush_quiet", 32'(evt_o), 0);
    end

    // Asynchronous reset mid-emission.
    evt_i = 6'h3F; did_i = 24'h77; pid_v_i = 1'b1;
    step();
    evt_i = '0; pid_v_i = 1'b0;
    step();
    chk("rstm_p0", 32'(evt_o), 32'h01);
    step();
    chk("rstm_p1", 32'(evt_o), 32'h02);
    rst = 1'b1;
    #1;
    chk("rstm_evt", 32'(evt_o), 0);
    chk("rstm_did", 32'(did_o), 0);
    chk("rstm_pidv", 32'(pid_v_o), 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("rstm_quiet", 32'(evt_o), 0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
